icdf_segment_eval: RTL and testbench
====================================

Name: icdf_segment_eval

Overview:
- Downstream consumer of the leading-zero detector in the Gaussian noise generator datapath.
- Takes the detector's 7-bit segment code, the fraction bits that follow the detected run, and a sign bit.
- Looks up per-segment piecewise-linear inverse-CDF coefficients (c1, c0) in a writable table and evaluates y = c0 + c1*frac.
- Emits a signed, saturated Gaussian sample through a 3-stage valid/ready pipeline.

Parameters:
- SEG_W, 7, segment code width; the table has 2^SEG_W entries.
- FRAC_W, 16, fraction input width, unsigned, Q0.FRAC_W.
- C1_W, 18, slope coefficient width, unsigned.
- C0_W, 18, offset coefficient width, unsigned.
- OUT_W, 16, output sample width, two's complement.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept an input this cycle
- in_seg  in  SEG_W  segment code {position[5:0], next bit} from the detector
- in_frac  in  FRAC_W  fraction bits following the detected run
- in_sign  in  1  sample sign; 1 = negative
- cfg_we  in  1  coefficient table write strobe
- cfg_addr  in  SEG_W  table write address
- cfg_c1  in  C1_W  slope to write
- cfg_c0  in  C0_W  offset to write
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts the sample
- out_data  out  OUT_W  signed Gaussian sample
- sat_count  out  16  saturating count of saturated samples

Behaviour:
- Reset values:
  - rst is synchronous, active-high, on clk.
  - All stage valid bits = 0, out_valid = 0, out_data = 0, sat_count = 0.
  - Table contents are not reset.
  - in_ready = 1 in the cycle after reset is released.
- Stall:
  - adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - All pipeline registers, including valid bits, load only when adv = 1; otherwise they hold.
  - A transfer occurs on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
- Pipeline, latency 3 cycles from input accept to out_valid with no stall:
  - S1: register seg, frac, sign, valid; synchronous table read at in_seg gives c1, c0.
  - S2: prod = c1 * frac, full C1_W+FRAC_W bits, unsigned; carry c0, sign, valid.
  - S3: mag = c0 + (prod >> FRAC_W), truncating. If mag > 2^(OUT_W-1)-1, clamp to 2^(OUT_W-1)-1 and flag saturation. out_data = sign ? -mag : mag; load out_valid.
- Throughput: one sample per cycle when out_ready is held high.
- sat_count:
  - Increments by 1 when a saturated sample is loaded into the S3 register.
  - Sticks at 0xFFFF.
- Coefficient table:
  - 2^SEG_W entries of {c1, c0}.
  - Write takes effect at the clock edge where cfg_we = 1; writes are accepted regardless of stall.
  - If a write and an S1 read hit the same address in the same cycle, the read returns old data.
  - A write during a stall does not alter coefficients already captured in S1/S2.
- Boundaries:
  - frac = 0 gives mag = c0.
  - Negative zero is output as 0.
  - Output can never be -2^(OUT_W-1), because of the symmetric clamp.
  - An input presented while in_ready = 0 is not accepted and must be held by upstream.
  - rst mid-operation flushes all in-flight samples the next cycle with no output transfer; the table is retained.
  - in_seg values the detector never produces (position 0) still index the table normally.

Decomposition:
- Shared package gng_pkg holds:
  - SEG_W, FRAC_W, C1_W, C0_W, OUT_W defaults
  - the coefficient-entry struct {c1, c0}
  - the SAT_MAX constant
- One sub-module: icdf_coef_ram, a simple dual-port synchronous RAM (1 write port, 1 read port with enable, read-before-write). It isolates the memory for later inference or ROM substitution.

Test Plan:
1. Basic evaluation: write addr 5 with c1 = 0x01000, c0 = 100; send seg = 5, frac = 0x8000, sign = 0 → 3 cycles later out_data = 0x0864 (2148); sat_count = 0.
2. Negative sample: same entry, sign = 1 → out_data = 0xF79C (-2148).
3. Saturation: write addr 9 with c1 = 0x3FFFF, c0 = 0x3FFFF; send frac = 0xFFFF, sign = 0 then sign = 1 → 0x7FFF then 0x8001; sat_count = 2.
4. Backpressure:
   - Stream 6 samples with out_ready low for 4 cycles mid-stream.
   - in_ready must drop in the same cycle out_valid && !out_ready.
   - All 6 outputs must appear in order with no loss or duplication; out_data must be stable while stalled.
5. Write/read collision:
   - Program addr 3 with c1 = 0, c0 = 10.
   - In the same cycle, accept seg = 3 and write addr 3 with c0 = 20 → output 10.
   - Next sample at seg = 3 → output 20.
6. Reset mid-stream: assert rst for 1 cycle with 3 samples in flight → out_valid = 0 and sat_count = 0 next cycle; no stale outputs afterward; table entries still read the previously written values.

Source files
------------

// File: rtl/gng_pkg.sv
// Shared widths, coefficient entry layout and clamp limit for the Gaussian noise generator datapath.
package gng_pkg;

    localparam int unsigned SEG_W     = 7;
    localparam int unsigned FRAC_W    = 16;
    localparam int unsigned C1_W      = 18;
    localparam int unsigned C0_W      = 18;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned TBL_DEPTH = 1 << SEG_W;
    localparam int unsigned PROD_W    = C1_W + FRAC_W;
    // One extra bit so c0 plus the integer part of the product cannot wrap
    localparam int unsigned MAG_W     = C0_W + 1;
    localparam int unsigned SCNT_W    = 16;

    localparam logic [OUT_W-1:0] SAT_MAX = OUT_W'((1 << (OUT_W - 1)) - 1);

    typedef struct packed {
        logic [C1_W-1:0] c1;
        logic [C0_W-1:0] c0;
    } coef_t;

    localparam int unsigned COEF_W = $bits(coef_t);

endpackage

// File: rtl/icdf_coef_ram.sv
// Simple dual-port synchronous coefficient RAM: one write port, one enabled read port, read-before-write.
module icdf_coef_ram
    import gng_pkg::*;
#(
    parameter int unsigned AW = SEG_W,
    parameter int unsigned DW = COEF_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1 << AW) - 1];

    // Same-address read and write in one cycle returns the old word
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/icdf_segment_eval.sv
// Piecewise-linear inverse-CDF evaluator: table lookup per segment, y = c0 + c1*frac, sign and
// symmetric saturation, through a 3-stage valid/ready pipeline that stalls as one unit.
module icdf_segment_eval
    import gng_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEG_W-1:0]  in_seg,
    input  logic [FRAC_W-1:0] in_frac,
    input  logic              in_sign,
    input  logic              cfg_we,
    input  logic [SEG_W-1:0]  cfg_addr,
    input  logic [C1_W-1:0]   cfg_c1,
    input  logic [C0_W-1:0]   cfg_c0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [SCNT_W-1:0] sat_count
);

    logic adv;

    coef_t             wr_entry;
    logic [COEF_W-1:0] rd_raw;
    coef_t             s1_coef;

    logic              s1_valid;
    logic [FRAC_W-1:0] s1_frac;
    logic              s1_sign;

    logic              s2_valid;
    logic [PROD_W-1:0] s2_prod;
    logic [C0_W-1:0]   s2_c0;
    logic              s2_sign;

    logic [MAG_W-1:0]  mag_c;
    logic              sat_c;
    logic [OUT_W-1:0]  mag_sat_c;

    // Whole pipeline advances together whenever the output slot is free or being drained
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign wr_entry = '{c1: cfg_c1, c0: cfg_c0};
    assign s1_coef  = coef_t'(rd_raw);

    // Read enable follows adv so a stalled S1 keeps the coefficients it already captured
    icdf_coef_ram #(
        .AW (SEG_W),
        .DW (COEF_W)
    ) u_coef_ram (
        .clk   (clk),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (wr_entry),
        .re    (adv),
        .raddr (in_seg),
        .rdata (rd_raw)
    );

    always_comb begin
        mag_c     = MAG_W'(s2_c0) + MAG_W'(s2_prod >> FRAC_W);
        sat_c     = mag_c > MAG_W'(SAT_MAX);
        mag_sat_c = sat_c ? SAT_MAX : OUT_W'(mag_c);
    end

    // Control and output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_count <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            // Clamp is symmetric, so negation never produces the most negative code
            out_data  <= s2_sign ? (OUT_W'(0) - mag_sat_c) : mag_sat_c;
            if (s2_valid && sat_c && (sat_count != {SCNT_W{1'b1}})) begin
                sat_count <= sat_count + SCNT_W'(1);
            end
        end
    end

    // Datapath registers carry no reset; they are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_frac <= in_frac;
            s1_sign <= in_sign;
            s2_prod <= PROD_W'(s1_coef.c1) * PROD_W'(s1_frac);
            s2_c0   <= s1_coef.c0;
            s2_sign <= s1_sign;
        end
    end

endmodule

// File: tb/tb_icdf_segment_eval.sv
// Self-checking bench for icdf_segment_eval: directed scenarios plus randomized traffic against
// an arithmetic reference model of the inverse-CDF evaluation.
module tb_icdf_segment_eval;
    import gng_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [SEG_W-1:0]  in_seg;
    logic [FRAC_W-1:0] in_frac;
    logic              in_sign;
    logic              cfg_we;
    logic [SEG_W-1:0]  cfg_addr;
    logic [C1_W-1:0]   cfg_c1;
    logic [C0_W-1:0]   cfg_c0;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [SCNT_W-1:0] sat_count;

    always #5 clk = ~clk;

    icdf_segment_eval dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_seg    (in_seg),
        .in_frac   (in_frac),
        .in_sign   (in_sign),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_c1    (cfg_c1),
        .cfg_c0    (cfg_c0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_count (sat_count)
    );

    int checks     = 0;
    int fails      = 0;
    int acc_count  = 0;
    int unexpected = 0;
    int timeouts   = 0;

    logic [OUT_W-1:0]  exp_q[$];
    logic [OUT_W-1:0]  got_q[$];
    logic [OUT_W-1:0]  want_q[$];
    logic [C1_W-1:0]   m_c1 [TBL_DEPTH];
    logic [C0_W-1:0]   m_c0 [TBL_DEPTH];
    logic [SCNT_W-1:0] exp_sat = '0;

    // Reference: integer arithmetic on the mathematical definition, clamp to +/-(2^(OUT_W-1)-1)
    function automatic logic [OUT_W-1:0] ref_eval(input longint c1, input longint c0,
                                                  input longint frac, input bit sign,
                                                  output bit sat);
        longint mag;
        longint lim;
        lim = (longint'(1) << (OUT_W - 1)) - 1;
        mag = c0 + (c1 * frac) / (longint'(1) << FRAC_W);
        sat = (mag > lim);
        if (sat) mag = lim;
        if (sign) mag = -mag;
        return OUT_W'(mag);
    endfunction

    // Observer: just before each rising edge, predict which transfers that edge performs
    always begin
        bit               s;
        logic [OUT_W-1:0] v;
        @(negedge clk);
        #2;
        if (rst) begin
            exp_q.delete();
            exp_sat = '0;
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (exp_q.size() > 0) want_q.push_back(exp_q.pop_front());
                else unexpected++;
            end
            if (in_valid && in_ready) begin
                v = ref_eval(longint'(m_c1[in_seg]), longint'(m_c0[in_seg]),
                             longint'(in_frac), in_sign, s);
                exp_q.push_back(v);
                acc_count++;
                if (s && exp_sat != 16'hFFFF) exp_sat++;
            end
        end
        if (cfg_we) begin
            m_c1[cfg_addr] = cfg_c1;
            m_c0[cfg_addr] = cfg_c0;
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_write(input logic [SEG_W-1:0] a, input logic [C1_W-1:0] c1,
                             input logic [C0_W-1:0] c0);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_c1   = c1;
        cfg_c0   = c0;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Present one sample and hold it until accepted; leaves in_valid asserted
    task automatic send(input logic [SEG_W-1:0] seg, input logic [FRAC_W-1:0] frac,
                        input logic sign, output int waited);
        int n;
        n        = acc_count;
        in_valid = 1'b1;
        in_seg   = seg;
        in_frac  = frac;
        in_sign  = sign;
        waited   = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (acc_count == n && waited < 200);
        if (acc_count == n) timeouts++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        idle();
        out_ready = 1'b1;
        while ((exp_q.size() > 0 || out_valid) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) timeouts++;
    endtask

    task automatic clear_obs();
        got_q.delete();
        want_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        out_ready = 1'b1;
        in_seg = '0; in_frac = '0; in_sign = 1'b0;
        cfg_addr = '0; cfg_c1 = '0; cfg_c0 = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin fails++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        checks++; if (sat_count !== 16'h0000) begin fails++; $display("FAIL reset_sat_count: got %h want 0000", sat_count); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        int w;
        @(negedge clk);
        out_ready = 1'b1;
        cfg_write(7'd5, 18'h01000, 18'd100);
        clear_obs();
        send(7'd5, 16'h8000, 1'b0, w);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_latency_c1: out_valid got %b want 0", out_valid); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_latency_c2: out_valid got %b want 0", out_valid); end
        @(negedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency_c3: out_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 16'h0864) begin fails++; $display("FAIL basic_pos: got %h want 0864", out_data); end
        @(negedge clk);
        send(7'd5, 16'h8000, 1'b1, w);
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[1] !== 16'hF79C) begin
            fails++; $display("FAIL basic_neg: got %0d outputs, last %h want F79C", got_q.size(), got_q.size() > 0 ? got_q[got_q.size()-1] : 16'h0);
        end
        checks++; if (sat_count !== 16'h0000) begin fails++; $display("FAIL basic_sat_count: got %h want 0000", sat_count); end
    endtask

    task automatic test_saturation();
        int w;
        @(negedge clk);
        cfg_write(7'd9, 18'h3FFFF, 18'h3FFFF);
        clear_obs();
        send(7'd9, 16'hFFFF, 1'b0, w);
        send(7'd9, 16'hFFFF, 1'b1, w);
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 16'h7FFF || got_q[1] !== 16'h8001) begin
            fails++; $display("FAIL sat_values: count %0d, got %h %h want 7FFF 8001", got_q.size(),
                              got_q.size() > 0 ? got_q[0] : 16'h0, got_q.size() > 1 ? got_q[1] : 16'h0);
        end
        checks++; if (sat_count !== 16'd2) begin fails++; $display("FAIL sat_count: got %0d want 2", sat_count); end
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] held;
        bit               have_held;
        logic [OUT_W-1:0] g;
        logic [OUT_W-1:0] e;
        @(negedge clk);
        out_ready = 1'b1;
        clear_obs();
        have_held = 1'b0;
        held      = '0;
        fork
            begin
                int w;
                for (int i = 0; i < 6; i++) begin
                    send(($urandom % 2) ? 7'd5 : 7'd9, 16'($urandom), 1'($urandom), w);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    #1;
                    if (out_valid) begin
                        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0 in stall cycle %0d", in_ready, i); end
                        if (have_held) begin
                            checks++; if (out_data !== held) begin fails++; $display("FAIL bp_stable: got %h want %h", out_data, held); end
                        end
                        held      = out_data;
                        have_held = 1'b1;
                    end
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        checks++; if (got_q.size() != 6) begin fails++; $display("FAIL bp_count: got %0d want 6", got_q.size()); end
        while (got_q.size() > 0 && want_q.size() > 0) begin
            g = got_q.pop_front();
            e = want_q.pop_front();
            checks++; if (g !== e) begin fails++; $display("FAIL bp_data: got %h want %h", g, e); end
        end
    endtask

    task automatic test_collision();
        int w;
        @(negedge clk);
        out_ready = 1'b1;
        cfg_write(7'd3, 18'd0, 18'd10);
        clear_obs();
        cfg_we   = 1'b1;
        cfg_addr = 7'd3;
        cfg_c1   = 18'd0;
        cfg_c0   = 18'd20;
        send(7'd3, 16'($urandom), 1'b0, w);
        cfg_we = 1'b0;
        send(7'd3, 16'($urandom), 1'b0, w);
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 16'd10) begin
            fails++; $display("FAIL collision_old: got %0d (count %0d) want 10", got_q.size() > 0 ? got_q[0] : 16'h0, got_q.size());
        end
        checks++;
        if (got_q.size() != 2 || got_q[1] !== 16'd20) begin
            fails++; $display("FAIL collision_new: got %0d (count %0d) want 20", got_q.size() > 1 ? got_q[1] : 16'h0, got_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        int w;
        @(negedge clk);
        out_ready = 1'b1;
        clear_obs();
        send(7'd9, 16'hFFFF, 1'b0, w);
        send(7'd5, 16'h8000, 1'b0, w);
        send(7'd9, 16'hFFFF, 1'b1, w);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        checks++; if (sat_count !== 16'h0000) begin fails++; $display("FAIL rstmid_sat_count: got %h want 0000", sat_count); end
        repeat (6) @(negedge clk);
        checks++; if (got_q.size() != 0) begin fails++; $display("FAIL rstmid_stale: got %0d outputs want 0", got_q.size()); end
        send(7'd5, 16'h8000, 1'b0, w);
        send(7'd9, 16'hFFFF, 1'b1, w);
        drain();
        checks++;
        if (got_q.size() != 2 || got_q[0] !== 16'h0864 || got_q[1] !== 16'h8001) begin
            fails++; $display("FAIL rstmid_table: count %0d, got %h %h want 0864 8001", got_q.size(),
                              got_q.size() > 0 ? got_q[0] : 16'h0, got_q.size() > 1 ? got_q[1] : 16'h0);
        end
        checks++; if (sat_count !== 16'd1) begin fails++; $display("FAIL rstmid_sat_after: got %0d want 1", sat_count); end
    endtask

    task automatic test_back_to_back();
        int               w;
        int               slow;
        logic [OUT_W-1:0] g;
        logic [OUT_W-1:0] e;
        @(negedge clk);
        out_ready = 1'b1;
        clear_obs();
        slow = 0;
        for (int i = 0; i < 20; i++) begin
            send(($urandom % 2) ? 7'd5 : 7'd9, 16'($urandom), 1'($urandom), w);
            if (w != 1) slow++;
        end
        drain();
        checks++; if (slow !== 0) begin fails++; $display("FAIL b2b_throughput: got %0d slow accepts want 0", slow); end
        checks++; if (got_q.size() != 20) begin fails++; $display("FAIL b2b_count: got %0d want 20", got_q.size()); end
        while (got_q.size() > 0 && want_q.size() > 0) begin
            g = got_q.pop_front();
            e = want_q.pop_front();
            checks++; if (g !== e) begin fails++; $display("FAIL b2b_data: got %h want %h", g, e); end
        end
    endtask

    task automatic test_random();
        int               last;
        int               n_out;
        logic [OUT_W-1:0] g;
        logic [OUT_W-1:0] e;
        @(negedge clk);
        for (int a = 0; a < int'(TBL_DEPTH); a++) begin
            cfg_write(SEG_W'(a), C1_W'($urandom) >> $urandom_range(0, 6), C0_W'($urandom_range(0, 36000)));
        end
        clear_obs();
        in_valid = 1'b0;
        last = acc_count;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc_count != last) begin
                in_valid = ($urandom % 3) != 0;
                in_seg   = SEG_W'($urandom);
                case ($urandom % 5)
                    0:       in_frac = '0;
                    1:       in_frac = '1;
                    default: in_frac = FRAC_W'($urandom);
                endcase
                in_sign  = 1'($urandom);
            end
            last      = acc_count;
            cfg_we    = ($urandom % 4) == 0;
            cfg_addr  = ($urandom % 2) ? in_seg : SEG_W'($urandom);
            cfg_c1    = C1_W'($urandom) >> $urandom_range(0, 6);
            cfg_c0    = C0_W'($urandom_range(0, 36000));
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
        end
        drain();
        n_out = got_q.size();
        checks++; if (n_out != want_q.size() || n_out == 0) begin fails++; $display("FAIL rand_count: got %0d outputs want %0d", n_out, want_q.size()); end
        while (got_q.size() > 0 && want_q.size() > 0) begin
            g = got_q.pop_front();
            e = want_q.pop_front();
            checks++; if (g !== e) begin fails++; $display("FAIL rand_data: got %h want %h", g, e); end
        end
        checks++; if (sat_count !== exp_sat) begin fails++; $display("FAIL rand_sat_count: got %0d want %0d", sat_count, exp_sat); end
    endtask

    task automatic test_integrity();
        checks++; if (unexpected !== 0) begin fails++; $display("FAIL integrity_unexpected: got %0d extra outputs want 0", unexpected); end
        checks++; if (timeouts !== 0) begin fails++; $display("FAIL integrity_timeouts: got %0d expired waits want 0", timeouts); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_collision();
        test_reset_midstream();
        test_back_to_back();
        test_random();
        test_integrity();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", checks, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
